pbs_battle_dp: RTL and testbench

Parametrised battle datapath for the PBS turn-based battle system. It resolves one attack turn per `start` request: it selects the move (player-supplied or AI-random), rolls accuracy against an internal LFSR, applies saturating damage to the opposing combatant's HP, and raises a one-cycle `done`. It sits under the battle control FSM. Compared with the previous datapath, it adds configurable HP/damage widths, a configurable move table, a busy/done handshake, KO detection and a new-game restart.

---
 rtl/pbs_battle_dp.sv | 131 +++++++++++++
 tb/tb_pbs_battle_dp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbs_battle_dp.sv
// Battle datapath for the PBS turn-based battle system: resolves one attack turn
// per start request (move select, accuracy roll, saturating damage, KO detect).
module pbs_battle_dp #(
  parameter int HP_W   = 4,
  parameter int MAX_HP = 9,
  parameter int MOVE_W = 2,
  parameter int DMG_W  = 4,
  parameter logic [(2**MOVE_W)*DMG_W-1:0] DMG_TABLE = 16'h5321,
  parameter logic [(2**MOVE_W)*4-1:0]     ACC_TABLE = 16'h48CF,
  parameter logic [7:0]                   LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              attacker,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              new_game,
  output logic              busy,
  output logic              done,
  output logic [MOVE_W-1:0] used_move,
  output logic              hit,
  output logic [DMG_W-1:0]  dmg_dealt,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   ai_hp,
  output logic              p_ko,
  output logic              ai_ko
);

  localparam int CMP_W = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam logic [HP_W-1:0] HP_INIT = HP_W'(MAX_HP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROLL,
    S_APPLY,
    S_DONE
  } state_t;

  state_t              state;
  logic [7:0]          lfsr;
  logic                att_p0;
  logic [MOVE_W-1:0]   pmv_p0;
  logic [MOVE_W-1:0]   sel_mv;
  logic [DMG_W-1:0]    dmg_p1;
  logic [3:0]          acc_p1;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0]  hp,
                                              input logic [DMG_W-1:0] dmg);
    logic [CMP_W-1:0] hp_x;
    logic [CMP_W-1:0] dmg_x;
    logic [CMP_W-1:0] diff;
    hp_x  = CMP_W'(hp);
    dmg_x = CMP_W'(dmg);
    diff  = hp_x - dmg_x;
    return (hp_x > dmg_x) ? diff[HP_W-1:0] : '0;
  endfunction

  function automatic logic [DMG_W-1:0] dmg_of(input logic [MOVE_W-1:0] mv);
    return DMG_TABLE[int'(mv)*DMG_W +: DMG_W];
  endfunction

  function automatic logic [3:0] acc_of(input logic [MOVE_W-1:0] mv);
    return ACC_TABLE[int'(mv)*4 +: 4];
  endfunction

  assign sel_mv = att_p0 ? lfsr[MOVE_W-1:0] : pmv_p0;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign p_ko   = (p_hp == '0);
  assign ai_ko  = (ai_hp == '0);

  // Free-running random source; only rst restarts it
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      p_hp      <= HP_INIT;
      ai_hp     <= HP_INIT;
      hit       <= 1'b0;
      dmg_dealt <= '0;
      used_move <= '0;
    end else if (new_game) begin
      state     <= S_IDLE;
      p_hp      <= HP_INIT;
      ai_hp     <= HP_INIT;
      hit       <= 1'b0;
      dmg_dealt <= '0;
      used_move <= '0;
    end else begin
      case (state)
        // p0: capture the turn request
        S_IDLE: begin
          if (start && !p_ko && !ai_ko) begin
            att_p0 <= attacker;
            pmv_p0 <= p_move;
            state  <= S_FETCH;
          end
        end
        // p1: move selection and table lookup
        S_FETCH: begin
          used_move <= sel_mv;
          dmg_p1    <= dmg_of(sel_mv);
          acc_p1    <= acc_of(sel_mv);
          state     <= S_ROLL;
        end
        // p2: accuracy roll against the current LFSR high nibble
        S_ROLL: begin
          hit   <= (lfsr[7:4] <= acc_p1);
          state <= S_APPLY;
        end
        // p3: damage lands only on the side opposite the attacker
        S_APPLY: begin
          if (hit) begin
            if (att_p0) p_hp  <= sat_sub(p_hp, dmg_p1);
            else        ai_hp <= sat_sub(ai_hp, dmg_p1);
          end
          dmg_dealt <= hit ? dmg_p1 : '0;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbs_battle_dp.sv
// Directed bench for pbs_battle_dp: three instances with different accuracy tables.
module tb_pbs_battle_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start_v = '0;
  logic [2:0] att_v   = '0;
  logic [2:0] ng_v    = '0;
  logic [1:0] mv_v [3];
  logic [2:0] busy_o, done_o, hit_o, pko_o, aiko_o;
  logic [1:0] um_o   [3];
  logic [3:0] dmg_o  [3];
  logic [3:0] php_o  [3];
  logic [3:0] aihp_o [3];

  int n_chk = 0;
  int n_bad = 0;
  int m_php  [3];
  int m_aihp [3];
  int dmg_t [4]    = '{1, 2, 3, 5};
  int acc_t [3][4] = '{'{15, 12, 8, 4}, '{15, 15, 15, 15}, '{0, 12, 8, 4}};
  logic [7:0] m_lfsr;

  pbs_battle_dp u_def (
    .clk(clk), .rst(rst), .start(start_v[0]), .attacker(att_v[0]), .p_move(mv_v[0]),
    .new_game(ng_v[0]), .busy(busy_o[0]), .done(done_o[0]), .used_move(um_o[0]),
    .hit(hit_o[0]), .dmg_dealt(dmg_o[0]), .p_hp(php_o[0]), .ai_hp(aihp_o[0]),
    .p_ko(pko_o[0]), .ai_ko(aiko_o[0]));

  pbs_battle_dp #(.ACC_TABLE(16'hFFFF)) u_f15 (
    .clk(clk), .rst(rst), .start(start_v[1]), .attacker(att_v[1]), .p_move(mv_v[1]),
    .new_game(ng_v[1]), .busy(busy_o[1]), .done(done_o[1]), .used_move(um_o[1]),
    .hit(hit_o[1]), .dmg_dealt(dmg_o[1]), .p_hp(php_o[1]), .ai_hp(aihp_o[1]),
    .p_ko(pko_o[1]), .ai_ko(aiko_o[1]));

  pbs_battle_dp #(.ACC_TABLE(16'h48C0)) u_z0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .attacker(att_v[2]), .p_move(mv_v[2]),
    .new_game(ng_v[2]), .busy(busy_o[2]), .done(done_o[2]), .used_move(um_o[2]),
    .hit(hit_o[2]), .dmg_dealt(dmg_o[2]), .p_hp(php_o[2]), .ai_hp(aihp_o[2]),
    .p_ko(pko_o[2]), .ai_ko(aiko_o[2]));

  // Reference random source from seed 8'hA5
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_hp(input int u, input string tag);
    chk({tag, "_php"},  php_o[u],  m_php[u]);
    chk({tag, "_aihp"}, aihp_o[u], m_aihp[u]);
    chk({tag, "_pko"},  pko_o[u],  (m_php[u] == 0));
    chk({tag, "_aiko"}, aiko_o[u], (m_aihp[u] == 0));
  endtask

  task automatic run_turn(input int u, input bit att, input int mv);
    logic [1:0] emv;
    logic       ehit;
    int         d;
    att_v[u]   = att;
    mv_v[u]    = 2'(mv);
    start_v[u] = 1'b1;
    if (m_php[u] == 0 || m_aihp[u] == 0) begin
      step();
      start_v[u] = 1'b0;
      chk("ko_ignore_busy", busy_o[u], 0);
      step();
      chk("ko_ignore_busy2", busy_o[u], 0);
      chk_hp(u, "ko_ignore");
      return;
    end
    step();
    start_v[u] = 1'b0;
    chk("busy_rise", busy_o[u], 1);
    emv = att ? m_lfsr[1:0] : 2'(mv);
    step();
    chk("used_move", um_o[u], emv);
    ehit = (m_lfsr[7:4] <= 4'(acc_t[u][emv]));
    step();
    chk("hit", hit_o[u], ehit);
    chk("done_early", done_o[u], 0);
    d = ehit ? dmg_t[emv] : 0;
    if (att) m_php[u]  = (m_php[u]  > d) ? m_php[u]  - d : 0;
    else     m_aihp[u] = (m_aihp[u] > d) ? m_aihp[u] - d : 0;
    step();
    chk("done", done_o[u], 1);
    chk("dmg_dealt", dmg_o[u], d);
    chk_hp(u, "apply");
    step();
    chk("done_fall", done_o[u], 0);
    chk("busy_fall", busy_o[u], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    for (int i = 0; i < 3; i++) begin
      mv_v[i]   = '0;
      m_php[i]  = 9;
      m_aihp[i] = 9;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int u = 0; u < 3; u++) begin
      chk("rst_busy", busy_o[u], 0);
      chk("rst_done", done_o[u], 0);
      chk("rst_hit",  hit_o[u], 0);
      chk("rst_dmg",  dmg_o[u], 0);
      chk("rst_um",   um_o[u], 0);
      chk_hp(u, "rst");
    end

    // Player move 0 always hits for 1
    run_turn(0, 1'b0, 0);
    chk("t1_aihp_hand", aihp_o[0], 8);
    chk("t1_php_hand", php_o[0], 9);

    // Saturating KO and ignored start
    run_turn(1, 1'b0, 3);
    chk("f15_aihp4", aihp_o[1], 4);
    run_turn(1, 1'b0, 3);
    chk("f15_aihp0", aihp_o[1], 0);
    chk("f15_aiko", aiko_o[1], 1);
    run_turn(1, 1'b0, 3);

    // New game restores both sides
    ng_v[1] = 1'b1;
    step();
    ng_v[1] = 1'b0;
    m_php[1]  = 9;
    m_aihp[1] = 9;
    chk_hp(1, "ng");
    chk("ng_hit", hit_o[1], 0);
    chk("ng_dmg", dmg_o[1], 0);
    chk("ng_um",  um_o[1], 0);
    chk("ng_done", done_o[1], 0);
    run_turn(1, 1'b0, 1);
    chk("ng_next_aihp", aihp_o[1], 7);

    // Held start re-triggers every 5 cycles
    att_v[1] = 1'b0;
    mv_v[1]  = 2'd0;
    start_v[1] = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o[1]) nd++;
    end
    start_v[1] = 1'b0;
    m_aihp[1] = 5;
    chk("held_dones", nd, 2);
    chk("held_aihp", aihp_o[1], 5);
    chk("held_busy", busy_o[1], 0);

    // AI attacks the player
    for (int i = 0; i < 3; i++) run_turn(0, 1'b1, 0);
    chk("ai_turns_aihp", aihp_o[0], 8);

    // Zero accuracy: hits only on a zero high nibble
    for (int i = 0; i < 8; i++) run_turn(2, 1'b0, 0);

    // Reset during ROLL
    att_v[0] = 1'b0;
    mv_v[0]  = 2'd0;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      m_php[u]  = 9;
      m_aihp[u] = 9;
      chk("rroll_busy", busy_o[u], 0);
      chk_hp(u, "rroll");
    end
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_o[0]) nd++;
      step();
    end
    chk("rroll_no_done", nd, 0);
    run_turn(0, 1'b1, 0);

    // Start while busy is ignored
    att_v[0] = 1'b0;
    mv_v[0]  = 2'd0;
    start_v[0] = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      start_v[0] = (i == 1);
      if (done_o[0]) nd++;
    end
    start_v[0] = 1'b0;
    m_aihp[0] = m_aihp[0] - 1;
    chk("busy_start_dones", nd, 1);
    chk("busy_start_aihp", aihp_o[0], m_aihp[0]);
    chk("busy_start_busy", busy_o[0], 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
